// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared types and defaults for the serial image loader.
//   rx_state_t  : UART receiver FSM states (PARITY is only entered when the
//                 build defines UART_PARITY_EN)
//   DEF_*       : default link / image geometry constants
//   addr_w()    : address width needed to index n entries (minimum 1 bit)
// -----------------------------------------------------------------------------
package img_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_BPP          = 3;
  localparam int DEF_HIEGHT       = 30;
  localparam int DEF_WIDTH        = 30;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// Oversampling UART byte receiver running on the system clock.
// Frame: 8N1 by default; 8E1 when the build defines UART_PARITY_EN.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clk
//   byte_valid  out  1-cycle pulse, byte_data holds a good byte
//   byte_data   out  last received byte (LSB received first)
//   byte_err    out  1-cycle pulse, byte discarded (bad stop / parity bit)
// -----------------------------------------------------------------------------
module uart_rx_byte
  import img_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_q, state_d;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             mid;
`ifdef UART_PARITY_EN
  logic             par_err;
`endif

  assign mid       = (bit_cnt == MID);
  assign byte_data = shift_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // Resetting to 1 matches the idle line so no false start follows reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // The bit counter free-runs modulo CLKS_PER_BIT from the start edge, so
  // every bit is sampled when it hits MID, one full bit period apart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
`ifdef UART_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE || state_d == IDLE) begin
        bit_cnt <= '0;
      end else if (bit_cnt == LAST) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (state_q == START) begin
        bit_idx <= '0;
      end
      if (state_q == DATA && mid) begin
        shift_q <= {rx_sync, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef UART_PARITY_EN
      // Even parity: data bits XOR parity bit must be zero.
      if (state_q == PARITY && mid) begin
        par_err <= (^shift_q) ^ rx_sync;
      end
`endif
    end
  end

  // Next-state and the byte result strobes. The strobes are combinational
  // so the packer sees the byte in the stop-bit sample cycle itself.
  always_comb begin
    state_d    = state_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev && !rx_sync) state_d = START;
      end
      START: begin
        if (mid) state_d = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (mid && bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (mid) state_d = STOP;
      end
`endif
      STOP: begin
        if (mid) begin
          state_d = IDLE;
`ifdef UART_PARITY_EN
          byte_valid = rx_sync && !par_err;
          byte_err   = !rx_sync || par_err;
`else
          byte_valid = rx_sync;
          byte_err   = !rx_sync;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_pixel_loader.sv
// -----------------------------------------------------------------------------
// uart_pixel_loader
// Loads an image received over UART into the image RAM, BPP bytes per pixel,
// first byte in the most significant position, linear addresses from 0.
// Optional feature: define UART_PARITY_EN for 8E1 frames (default 8N1).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   rx         in   serial line, idle high
//   start      in   1-cycle pulse, (re)arms a load at address 0
//   wr_en      out  1-cycle RAM write strobe
//   wr_addr    out  pixel address 0..PEXILS-1
//   wr_data    out  assembled pixel
//   busy       out  armed and not yet done
//   load_done  out  all PEXILS pixels written; cleared by start/reset
//   frame_err  out  sticky, a byte was discarded
// -----------------------------------------------------------------------------
module uart_pixel_loader
  import img_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int BPP          = DEF_BPP,
  parameter int HIEGHT       = DEF_HIEGHT,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int PEXILS       = HIEGHT * WIDTH,
  parameter int SZ           = 8 * BPP,
  localparam int ADDR_W      = addr_w(PEXILS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SZ-1:0]     wr_data,
  output logic              busy,
  output logic              load_done,
  output logic              frame_err
);

  localparam int BC_W = addr_w(BPP);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BPP - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PEXILS - 1);

  logic            byte_valid;
  logic            byte_err;
  logic [7:0]      byte_data;
  logic [BC_W-1:0] byte_cnt;
  logic [SZ-1:0]   pixel;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err)
  );

  // wr_addr is the live address counter; it advances in the cycle after the
  // strobe so the strobe cycle still shows the address being written.
  // start has priority over everything, including a byte finishing with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
      byte_cnt  <= '0;
      pixel     <= '0;
    end else begin
      wr_en <= 1'b0;
      if (wr_en) begin
        wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
      end
      if (byte_err) begin
        frame_err <= 1'b1;
      end
      if (start) begin
        wr_addr   <= '0;
        byte_cnt  <= '0;
        pixel     <= '0;
        load_done <= 1'b0;
        frame_err <= 1'b0;
        busy      <= 1'b1;
      end else if (byte_valid && busy) begin
        if (byte_cnt == LAST_BYTE) begin
          wr_en    <= 1'b1;
          wr_data  <= {pixel[SZ-9:0], byte_data};
          byte_cnt <= '0;
          pixel    <= '0;
          if (wr_addr == LAST_ADDR) begin
            load_done <= 1'b1;
            busy      <= 1'b0;
          end
        end else begin
          pixel    <= {pixel[SZ-9:0], byte_data};
          byte_cnt <= byte_cnt + BC_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/uart_pixel_loader.md
Name: uart_pixel_loader

Overview:
- Upstream image source for the shrink/effects datapath. It replaces the fixed ROM contents with an image received over a serial link.
- Receives 8N1 UART bytes on the system clock and packs BPP consecutive bytes into one pixel.
- Writes each pixel into the image RAM through a single-cycle write strobe, with a linear address.
- Flags load completion so the processing stage can be started.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (Fsys/baudrate); must be >= 4.
- BPP, 3, bytes per pixel; first received byte lands in the MS byte of the pixel.
- HIEGHT, 30, image rows.
- WIDTH, 30, image columns.
- PEXILS, HIEGHT*WIDTH, pixels per image.
- SZ, 8*BPP, pixel width in bits.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- start  in  1  single-cycle arm pulse; starts or restarts a load at address 0.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  $clog2(PEXILS)  pixel address, 0..PEXILS-1.
- wr_data  out  SZ  assembled pixel.
- busy  out  1  high while armed and not done.
- load_done  out  1  high after PEXILS pixels are written; cleared only by start or reset.
- frame_err  out  1  sticky; a byte was discarded because of a bad stop bit (or parity, see Optional Feature).

Behaviour:
- Reset (rst low, async): all outputs 0, rx FSM to IDLE, byte/pixel/address counters 0, shift registers 0. Reset mid-frame abandons the partial byte and partial pixel.
- rx input passes through a 2-flop synchronizer (set to 1 on reset). All decisions use the synchronized signal, so it adds 2 clocks of latency.
- Bit counter runs 0..CLKS_PER_BIT-1. Data is sampled at count (CLKS_PER_BIT-1)/2, i.e. mid-bit.
- Rx FSM states:
  - IDLE: on a synchronized falling edge go to START and clear the bit counter.
  - START: at mid-bit, if rx is still 0 go to DATA; otherwise it was a glitch, return to IDLE with no error.
  - DATA: shift 8 bits LSB-first, one full bit period apart; after bit 7 go to STOP.
  - STOP: at mid-bit, if rx=1 the byte is valid, otherwise set frame_err and discard the byte. Return to IDLE in the same cycle, so back-to-back frames are accepted.
- Bytes are accepted only when busy=1. While not armed, the FSM still runs but valid bytes are dropped silently.
- Pixel assembly: each valid byte shifts in as pixel = {pixel[SZ-9:0], byte}. byte_cnt counts 0..BPP-1.
- On the BPP-th byte, the next cycle drives wr_en=1 with wr_data = the assembled pixel and wr_addr = the current address.
  - The address then increments and byte_cnt clears.
  - Latency from stop-bit mid-sample to wr_en is exactly 1 clock.
- After the write at address PEXILS-1: load_done=1 and busy=0 in the same cycle wr_en is high, and the address holds at 0. Later bytes are ignored and produce no wrap-around writes.
- A discarded (errored) byte does not advance byte_cnt. Pixel alignment is kept on the next good byte.
- start handling:
  - Clears address, byte_cnt, partial pixel, load_done and frame_err, and sets busy=1. This applies even mid-load, which restarts the load.
  - If start coincides with a completing byte, start wins and the byte is dropped.
- wr_en is never high for more than one consecutive cycle, because pixels are at least BPP*10 bit-times apart.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: frame is 8E1. The FSM adds a PARITY state between DATA and STOP, sampling one bit at mid-bit. If the received even parity mismatches, the byte is discarded and frame_err is set, even when the stop bit is good.
- Undefined: 8N1 as described above, and no PARITY state exists.

Decomposition:
- Shared package img_pkg holds:
  - the rx FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - default CLKS_PER_BIT, BPP, HIEGHT and WIDTH constants;
  - the function clog2-based ADDR_W.
- One natural sub-module, uart_rx_byte: synchronizer, bit counter and FSM. Outputs are byte_valid (1-cycle), byte_data[7:0] and byte_err (1-cycle).
- The top-level pixel packer and address counter stay in uart_pixel_loader.

Test Plan (CLKS_PER_BIT=8, BPP=3, HIEGHT=WIDTH=2 unless stated):
- Reset low mid-frame, then release -> all outputs 0; the next full frame with busy=0 produces no wr_en.
- start, then bytes 0x12,0x34,0x56 -> exactly one wr_en with wr_addr=0 and wr_data=0x123456, 1 clk after the third stop mid-sample.
- start, then 12 good bytes -> 4 writes at addresses 0..3. load_done=1 and busy=0 coincide with the 4th wr_en. A 13th byte produces no write.
- Byte 0xAA with stop bit 0, then 0x11,0x22,0x33 -> frame_err=1 sticky, a single write of 0x112233 at address 0.
- 3-clk low glitch on idle rx -> no byte, frame_err stays 0.
- With UART_PARITY_EN: byte 0x01 sent with parity bit 0 -> discarded, frame_err=1. The same byte with parity 1 is accepted.
